jellyvl_synctimer_adjuster_spreader: RTL

//  Next-generation adjust-pulse driver for the synctimer adjuster. Takes a signed phase/period

---
 rtl/jellyvl_synctimer_adjuster_spreader.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/jellyvl_synctimer_adjuster_spreader.sv
// Synctimer adjust-pulse spreader: distributes |request_value| unit pulses evenly over
// request_cycle clocks with a Bresenham accumulator and buffers them against adjust_ready.
module jellyvl_synctimer_adjuster_spreader #(
    parameter int unsigned CYCLE_WIDTH   = 32,
    parameter int unsigned CYCLE_Q       = 6,
    parameter int unsigned ERROR_WIDTH   = 32,
    parameter int unsigned ERROR_Q       = 8,
    parameter int unsigned PENDING_WIDTH = 4
) (
    input  logic                           reset,
    input  logic                           clk,
    input  logic                           enable,
    input  logic [ERROR_WIDTH+ERROR_Q-1:0] request_value,
    input  logic [CYCLE_WIDTH+CYCLE_Q-1:0] request_cycle,
    input  logic                           request_valid,
    output logic                           adjust_sign,
    output logic                           adjust_valid,
    input  logic                           adjust_ready,
    output logic                           status_busy,
    output logic [PENDING_WIDTH-1:0]       status_pending,
    output logic                           status_overflow,
    input  logic                           status_clear
);

    localparam int unsigned VAL_W = ERROR_WIDTH + ERROR_Q;
    localparam int unsigned CYC_W = CYCLE_WIDTH + CYCLE_Q;
    localparam int unsigned INC_W = VAL_W + CYCLE_Q;
    localparam int unsigned THR_W = CYC_W + ERROR_Q;
    localparam int unsigned ACC_W = ((INC_W > THR_W) ? INC_W : THR_W) + 2;

    localparam logic [VAL_W-1:0]         VAL_MIN  = {1'b1, {(VAL_W-1){1'b0}}};
    localparam logic [VAL_W-1:0]         VAL_MAX  = {1'b0, {(VAL_W-1){1'b1}}};
    localparam logic [PENDING_WIDTH-1:0] PEND_MAX = {PENDING_WIDTH{1'b1}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]               state,   state_next;
    logic [ACC_W-1:0]         acc,     acc_next;
    logic [ACC_W-1:0]         inc,     inc_next;
    logic [ACC_W-1:0]         thr,     thr_next;
    logic [CYCLE_WIDTH-1:0]   target,  target_next;
    logic [CYCLE_WIDTH-1:0]   elapsed, elapsed_next;
    logic                     sign_next;
    logic [PENDING_WIDTH-1:0] pending_next;
    logic                     valid_next;
    logic                     busy_next;
    logic                     overflow_next;

    logic [VAL_W-1:0] abs_value_c;
    logic [ACC_W-1:0] sum_c;
    logic [ACC_W-1:0] rem_c;
    logic             generate_c;
    logic             lost_c;
    logic             flush_c;
    logic             take_c;

    // Magnitude of the signed request; the most-negative code saturates
    always_comb begin
        abs_value_c = request_value;
        if (request_value[VAL_W-1]) begin
            if (request_value == VAL_MIN) begin
                abs_value_c = VAL_MAX;
            end else begin
                abs_value_c = ~request_value + VAL_W'(1);
            end
        end
    end

    // Next-state: request latch, accumulator step, pending counter and status
    always_comb begin
        state_next    = state;
        acc_next      = acc;
        inc_next      = inc;
        thr_next      = thr;
        target_next   = target;
        elapsed_next  = elapsed;
        sign_next     = adjust_sign;
        pending_next  = status_pending;
        overflow_next = status_overflow;
        sum_c         = acc + inc;
        rem_c         = sum_c - thr;
        generate_c    = 1'b0;
        lost_c        = 1'b0;
        flush_c       = 1'b0;
        take_c        = adjust_valid & adjust_ready;

        if (request_valid && (request_cycle != '0)) begin
            inc_next     = ACC_W'(abs_value_c) << CYCLE_Q;
            thr_next     = ACC_W'(request_cycle) << ERROR_Q;
            target_next  = request_cycle[CYC_W-1:CYCLE_Q];
            elapsed_next = '0;
            state_next   = ST_RUN;
            sign_next    = request_value[VAL_W-1];
            // A direction change discards residue and any queued opposite-sign pulses
            if (sign_next != adjust_sign) begin
                acc_next = '0;
                flush_c  = 1'b1;
            end
        end else if ((state == ST_RUN) && enable) begin
            if (sum_c >= thr) begin
                generate_c = 1'b1;
                if (rem_c >= thr) begin
                    acc_next = thr - ACC_W'(1);
                    lost_c   = 1'b1;
                end else begin
                    acc_next = rem_c;
                end
            end else begin
                acc_next = sum_c;
            end
            elapsed_next = elapsed + CYCLE_WIDTH'(1);
            if (elapsed_next >= target) begin
                state_next = ST_IDLE;
            end
        end

        if (flush_c) begin
            pending_next = '0;
        end else if (generate_c && !take_c) begin
            if (status_pending == PEND_MAX) begin
                lost_c = 1'b1;
            end else begin
                pending_next = status_pending + PENDING_WIDTH'(1);
            end
        end else if (!generate_c && take_c) begin
            pending_next = status_pending - PENDING_WIDTH'(1);
        end

        if (status_clear) begin
            overflow_next = 1'b0;
        end
        if (lost_c) begin
            overflow_next = 1'b1;
        end

        valid_next = (pending_next != '0);
        busy_next  = (state_next == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            acc             <= '0;
            inc             <= '0;
            thr             <= '0;
            target          <= '0;
            elapsed         <= '0;
            adjust_sign     <= 1'b0;
            adjust_valid    <= 1'b0;
            status_busy     <= 1'b0;
            status_pending  <= '0;
            status_overflow <= 1'b0;
        end else begin
            state           <= state_next;
            acc             <= acc_next;
            inc             <= inc_next;
            thr             <= thr_next;
            target          <= target_next;
            elapsed         <= elapsed_next;
            adjust_sign     <= sign_next;
            adjust_valid    <= valid_next;
            status_busy     <= busy_next;
            status_pending  <= pending_next;
            status_overflow <= overflow_next;
        end
    end

endmodule
